// File: rtl/redmule_tcdm_responder.sv
// TCDM memory-side responder for the RedMulE wide port.
// Word-addressed 32-bit backing array, combinational grant, in-order
// response queue with lrdy backpressure, and read/write grant counters.

package redmule_pkg;
    localparam int unsigned TCDM_DW = 288;
    localparam int unsigned TCDM_UW = 1;

    typedef struct packed {
        logic                   req;
        logic                   wen;     // 1 = read, 0 = write
        logic [TCDM_DW/8-1:0]   be;
        logic [3:0]             boffs;
        logic [31:0]            add;
        logic [TCDM_DW-1:0]     data;
        logic                   lrdy;
        logic [TCDM_UW-1:0]     user;
    } redmule_default_data_req_t;

    typedef struct packed {
        logic                   gnt;
        logic                   r_valid;
        logic [TCDM_DW-1:0]     r_data;
        logic                   r_opc;
        logic [TCDM_UW-1:0]     r_user;
    } redmule_default_data_rsp_t;
endpackage

module redmule_tcdm_responder
    import redmule_pkg::*;
#(
    // DATA_W has to agree with the width baked into the request/response structs
    parameter int unsigned DATA_W    = 288,
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  redmule_default_data_req_t tcdm_req_i,
    output redmule_default_data_rsp_t tcdm_rsp_o,
    input  logic                      stall_i,
    output logic [31:0]               n_reads_o,
    output logic [31:0]               n_writes_o
);

    localparam int unsigned NW = DATA_W / 32;
    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    // backing store, never reset
    logic [31:0]          r_mem [MEM_WORDS];

    // response queue storage and control
    logic [DATA_W-1:0]    r_q_data [RSP_DEPTH];
    logic                 r_q_opc  [RSP_DEPTH];
    logic [TCDM_UW-1:0]   r_q_user [RSP_DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_cnt;
    logic [31:0]          r_n_reads;
    logic [31:0]          r_n_writes;

    logic [31:0]          w_base;
    logic                 w_err;
    logic [AW-1:0]        w_idx   [NW];
    logic [31:0]          w_wword [NW];
    logic [DATA_W-1:0]    w_rd_data;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_gnt;
    logic                 w_push;
    logic                 w_wr;
    logic                 w_unused;

    // byte offset is meaningless for this word-addressed array
    assign w_unused = ^tcdm_req_i.boffs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // address decode: word base, per-beat indices and the error condition
    always_comb begin
        w_base = (tcdm_req_i.add - BASE_ADDR) >> 2;
        w_err  = (tcdm_req_i.add[1:0] != 2'b00) ||
                 (tcdm_req_i.add < BASE_ADDR) ||
                 (({1'b0, w_base} + 33'(NW)) > 33'(MEM_WORDS));
        for (int k = 0; k < NW; k++) begin
            w_idx[k] = AW'(w_base + 32'(k));
        end
    end

    // read sampling and byte-merged write words; error reads return zero
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NW; k++) begin
            w_wword[k] = r_mem[w_idx[k]];
            for (int b = 0; b < 4; b++) begin
                if (tcdm_req_i.be[4*k+b]) begin
                    w_wword[k][8*b +: 8] = tcdm_req_i.data[32*k+8*b +: 8];
                end
            end
            if (!w_err) begin
                w_rd_data[32*k +: 32] = r_mem[w_idx[k]];
            end
        end
    end

    // grant: a same-cycle pop frees a slot in a full queue
    always_comb begin
        w_valid = (r_cnt != '0);
        w_pop   = w_valid & tcdm_req_i.lrdy;
        w_gnt   = tcdm_req_i.req & ~stall_i &
                  ((r_cnt < CW'(RSP_DEPTH)) | w_pop);
        w_push  = w_gnt & tcdm_req_i.wen;
        w_wr    = w_gnt & ~tcdm_req_i.wen & ~w_err;
    end

    // array write at the grant edge; dropped on error
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int k = 0; k < NW; k++) begin
                r_mem[w_idx[k]] <= w_wword[k];
            end
        end
    end

    // queue payload: capture read data, opcode and user on push
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= w_rd_data;
            r_q_opc[r_wr_ptr]  <= w_err;
            r_q_user[r_wr_ptr] <= tcdm_req_i.user;
        end
    end

    // queue pointers, occupancy and transaction counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_n_reads  <= '0;
            r_n_writes <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
            if (w_gnt &&  tcdm_req_i.wen) r_n_reads  <= r_n_reads + 32'd1;
            if (w_gnt && !tcdm_req_i.wen) r_n_writes <= r_n_writes + 32'd1;
        end
    end

    // response: head of queue, zeroed while empty
    always_comb begin
        tcdm_rsp_o         = '0;
        tcdm_rsp_o.gnt     = w_gnt;
        tcdm_rsp_o.r_valid = w_valid;
        if (w_valid) begin
            tcdm_rsp_o.r_data = r_q_data[r_rd_ptr];
            tcdm_rsp_o.r_opc  = r_q_opc[r_rd_ptr];
            tcdm_rsp_o.r_user = r_q_user[r_rd_ptr];
        end
    end

    assign n_reads_o  = r_n_reads;
    assign n_writes_o = r_n_writes;

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Bench for redmule_tcdm_responder: per-cycle vector table with expected
// gnt/r_valid, plus a scoreboard of expected read responses.

module tb_redmule_tcdm_responder;
    import redmule_pkg::*;

    localparam int unsigned DW = 288;
    localparam int unsigned NW = DW / 32;
    localparam int unsigned MW = 4096;
    localparam logic [35:0] BEALL = 36'hF_FFFF_FFFF;

    typedef struct {
        bit          rq;
        bit          wn;
        logic [31:0] ad;
        logic [35:0] be;
        logic [31:0] db;
        bit          di;
        bit          us;
        bit          lr;
        bit          st;
        bit          eg;
        bit          ev;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          opc;
        logic          user;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      stall = 1'b0;
    redmule_default_data_req_t req;
    redmule_default_data_rsp_t rsp;
    logic [31:0]               n_reads, n_writes;

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned m_reads = 0;
    int unsigned m_writes = 0;
    logic [31:0] mm [int];
    exp_t        sb [$];
    vec_t        tbl [$];

    redmule_tcdm_responder #(
        .DATA_W(DW), .MEM_WORDS(MW), .BASE_ADDR(32'h0), .RSP_DEPTH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_rsp_o(rsp),
        .stall_i(stall), .n_reads_o(n_reads), .n_writes_o(n_writes)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit rq, bit wn, logic [31:0] ad, logic [35:0] be,
                                logic [31:0] db, bit di, bit us, bit lr, bit st,
                                bit eg, bit ev);
        vec_t v;
        v.rq = rq; v.wn = wn; v.ad = ad; v.be = be; v.db = db; v.di = di;
        v.us = us; v.lr = lr; v.st = st; v.eg = eg; v.ev = ev;
        return v;
    endfunction

    function automatic vec_t idle(bit ev);
        return mk(0, 1, 32'h0, 36'h0, 32'h0, 0, 0, 1, 0, 0, ev);
    endfunction

    function automatic logic [DW-1:0] mkdata(logic [31:0] db, bit di);
        logic [DW-1:0] d;
        for (int k = 0; k < NW; k++) d[32*k +: 32] = db + (di ? 32'(k) : 32'd0);
        return d;
    endfunction

    function automatic bit is_err(logic [31:0] ad);
        return (ad[1:0] != 2'b00) || ((33'(ad >> 2) + 33'(NW)) > 33'(MW));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one cycle: drive at posedge+1, check and update model at negedge
    task automatic step(input vec_t v);
        logic [DW-1:0] d;
        exp_t          e;
        int            base;
        d = mkdata(v.db, v.di);
        req.req = v.rq; req.wen = v.wn; req.add = v.ad; req.be = v.be;
        req.data = d; req.user = v.us; req.lrdy = v.lr;
        req.boffs = 4'($urandom_range(0, 15));
        stall = v.st;
        @(negedge clk);
        chk("gnt", 64'(rsp.gnt), 64'(v.eg));
        chk("r_valid", 64'(rsp.r_valid), 64'(v.ev));
        chk("counters", {n_reads, n_writes}, {m_reads, m_writes});
        if (v.rq && v.eg) begin
            base = int'(v.ad >> 2);
            if (v.wn) begin
                m_reads++;
                e.opc = is_err(v.ad);
                e.user = v.us;
                e.data = '0;
                if (!e.opc)
                    for (int k = 0; k < NW; k++)
                        e.data[32*k +: 32] = mm.exists(base + k) ? mm[base + k] : 32'h0;
                sb.push_back(e);
            end else begin
                m_writes++;
                if (!is_err(v.ad))
                    for (int k = 0; k < NW; k++) begin
                        if (!mm.exists(base + k)) mm[base + k] = 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (v.be[4*k+b]) mm[base + k][8*b +: 8] = d[32*k+8*b +: 8];
                    end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // scoreboard: head compared every valid cycle, popped on lrdy
    always @(negedge clk) begin
        if (!rst && rsp.r_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got r_valid=1 expected no response at %0t", $time);
            end else begin
                if ({rsp.r_data, rsp.r_opc, rsp.r_user} !== {sb[0].data, sb[0].opc, sb[0].user}) begin
                    n_fail++;
                    $display("FAIL rsp: got data=%h opc=%0b user=%0b expected data=%h opc=%0b user=%0b",
                             rsp.r_data, rsp.r_opc, rsp.r_user, sb[0].data, sb[0].opc, sb[0].user);
                end
                if (req.lrdy) void'(sb.pop_front());
            end
        end
    end

    initial begin
        req = '0;
        req.lrdy = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 64'(rsp.gnt), 64'd0);
        chk("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        chk("rst_r_data", 64'(rsp.r_data), 64'd0);
        chk("rst_r_opc_user", {rsp.r_opc, rsp.r_user}, 64'd0);
        chk("rst_counters", {n_reads, n_writes}, 64'd0);
        @(posedge clk);
        #1;

        // aligned write then read, one-cycle latency
        tbl.push_back(mk(1, 0, 32'h100, BEALL, 32'hA000_0000, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h100, BEALL, 32'h0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(idle(1));
        tbl.push_back(idle(0));
        // partial byte enables over a zeroed beat
        tbl.push_back(mk(1, 0, 32'h100, BEALL, 32'h0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h100, 36'h5, 32'hFFFF_FFFF, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h100, 36'h0, 32'h0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(idle(1));
        // backpressure: queue fills, third read waits for first pop
        tbl.push_back(mk(1, 1, 32'h100, 36'h0, 32'h0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h100, 36'h0, 32'h0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 32'h100, 36'h0, 32'h0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h100, 36'h0, 32'h0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'h100, 36'h0, 32'h0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(idle(1));
        tbl.push_back(idle(1));
        tbl.push_back(idle(0));
        // stall injection for 5 cycles, then granted
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 32'h140, BEALL, 32'hB000_0000, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h140, BEALL, 32'hB000_0000, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h140, 36'h0, 32'h0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(idle(1));
        // error reads: misaligned, past end of array
        tbl.push_back(mk(1, 1, 32'h102, 36'h0, 32'h0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h3FF0, 36'h0, 32'h0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(idle(1));
        // error writes are dropped: 0x100 must still hold the partial pattern
        tbl.push_back(mk(1, 0, 32'h102, BEALL, 32'hDEAD_0000, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h3FF0, BEALL, 32'hDEAD_1000, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h100, 36'h0, 32'h0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(idle(1));
        // last in-range beat of the array
        tbl.push_back(mk(1, 0, 32'h3FDC, BEALL, 32'hC000_0000, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h3FDC, 36'h0, 32'h0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(idle(1));
        tbl.push_back(idle(0));

        foreach (tbl[i]) step(tbl[i]);

        // reset with two responses queued
        step(mk(1, 1, 32'h140, 36'h0, 32'h0, 0, 0, 0, 0, 1, 0));
        step(mk(1, 1, 32'h140, 36'h0, 32'h0, 0, 1, 0, 0, 1, 1));
        rst = 1'b1;
        req.req = 1'b0;
        req.lrdy = 1'b1;
        @(negedge clk);
        sb.delete();
        m_reads = 0;
        m_writes = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_r_valid", 64'(rsp.r_valid), 64'd0);
        chk("post_rst_counters", {n_reads, n_writes}, 64'd0);
        @(posedge clk);
        #1;
        step(mk(1, 1, 32'h140, 36'h0, 32'h0, 0, 1, 1, 0, 1, 0));
        step(idle(1));
        step(idle(0));

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
